// File: rtl/ifetch_refill_arbiter.sv
// ifetch_refill_arbiter: serves icache demand misses from the prefetch buffer or an AXI burst,
// and shares the single AXI read master with the prefetcher when no demand is pending.
module ifetch_refill_arbiter #(
   parameter int BURST_LENGTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_req,
   input  logic [31:0] miss_addr,
   output logic        refill_valid,
   output logic [31:0] refill_addr,
   output logic [31:0] refill_data [0:7],
   input  logic [31:0] buff_addr,
   input  logic [31:0] buff_data [0:7],
   input  logic        buff_ready,
   input  logic [31:0] pf_araddr,
   input  logic        pf_arvalid,
   output logic        pf_arready,
   output logic [31:0] pf_rdata,
   output logic        pf_rvalid,
   output logic        pf_rlast,
   input  logic        pf_rready,
   output logic [3:0]  m_arid,
   output logic [31:0] m_araddr,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic        m_rvalid,
   input  logic        m_rlast,
   input  logic [1:0]  m_rresp,
   output logic        m_rready
);
   typedef enum logic [2:0] {IDLE, HIT, C_AR, C_R, DONE, P_AR, P_R} state_t;
   state_t      state_q, state_d;
   logic        pending_q;
   logic [26:0] line_q;
   logic [31:0] addr_q;
   logic [31:0] data_q [0:7];
   logic [2:0]  count_q;
   logic        unused_bits;
   assign unused_bits = ^{m_rresp, miss_addr[4:0], buff_addr[4:0]};
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pending_q && buff_ready && buff_addr[31:5] == line_q) state_d = HIT;
            else if (pending_q) state_d = C_AR;
            else if (pf_arvalid && !miss_req) state_d = P_AR;
         end
         HIT:     state_d = IDLE;
         C_AR:    state_d = m_arready ? C_R : C_AR;
         C_R:     state_d = (m_rvalid && m_rlast) ? DONE : C_R;
         DONE:    state_d = IDLE;
         P_AR:    state_d = (pf_arvalid && m_arready) ? P_R : P_AR;
         P_R:     state_d = (m_rvalid && pf_rready && m_rlast) ? IDLE : P_R;
         default: state_d = IDLE;
      endcase
   end
   // The in-flight request address lives in addr_q so later misses only retarget line_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         line_q    <= '0;
         addr_q    <= '0;
         count_q   <= '0;
         data_q    <= '{default: '0};
      end else begin
         state_q   <= state_d;
         pending_q <= miss_req | (pending_q & (state_q != IDLE));
         if (miss_req) line_q <= miss_addr[31:5];
         if (state_q == IDLE && pending_q) addr_q <= {line_q, 5'b0};
         if (state_d == HIT) data_q <= buff_data;
         else if (state_q == C_R && m_rvalid) data_q[count_q] <= m_rdata;
         if (state_q == DONE) count_q <= '0;
         else if (state_q == C_R && m_rvalid && count_q != 3'd7) count_q <= count_q + 3'd1;
      end
   end
   assign refill_valid = (state_q == HIT) || (state_q == DONE);
   assign refill_addr  = addr_q;
   assign refill_data  = data_q;
   assign m_arid       = (state_q == P_AR) ? 4'd1 : 4'd0;
   assign m_araddr     = (state_q == C_AR) ? addr_q : (state_q == P_AR) ? pf_araddr : '0;
   assign m_arlen      = 8'(BURST_LENGTH - 1);
   assign m_arsize     = 3'd2;
   assign m_arburst    = 2'b01;
   assign m_arvalid    = (state_q == C_AR) || (state_q == P_AR && pf_arvalid);
   assign pf_arready   = (state_q == P_AR) && m_arready;
   assign m_rready     = (state_q == C_R) || (state_q == P_R && pf_rready);
   assign pf_rdata     = (state_q == P_R) ? m_rdata : '0;
   assign pf_rvalid    = (state_q == P_R) && m_rvalid;
   assign pf_rlast     = (state_q == P_R) && m_rlast;
endmodule

// File: tb/tb_ifetch_refill_arbiter.sv
// tb_ifetch_refill_arbiter: directed and randomized demand/prefetch traffic checked against
// transaction-level expectations (line alignment, buffer match, beat ordering).
module tb_ifetch_refill_arbiter;
   localparam int BL = 8;
   logic        clk = 1'b0, rst = 1'b0;
   logic        miss_req = 1'b0, buff_ready = 1'b0, pf_arvalid = 1'b0, pf_rready = 1'b0;
   logic        m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
   logic [31:0] miss_addr = '0, buff_addr = '0, pf_araddr = '0, m_rdata = '0;
   logic [1:0]  m_rresp = 2'b10;
   logic [31:0] bdata [0:7];
   logic [31:0] rdata [0:7];
   logic        refill_valid, pf_arready, pf_rvalid, pf_rlast, m_arvalid, m_rready;
   logic [31:0] refill_addr, pf_rdata, m_araddr;
   logic [31:0] refill_data [0:7];
   logic [3:0]  m_arid;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   int checks = 0, failures = 0;
   logic [31:0] a, p;

   ifetch_refill_arbiter #(.BURST_LENGTH(BL)) dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_data(refill_data),
      .buff_addr(buff_addr), .buff_data(bdata), .buff_ready(buff_ready),
      .pf_araddr(pf_araddr), .pf_arvalid(pf_arvalid), .pf_arready(pf_arready),
      .pf_rdata(pf_rdata), .pf_rvalid(pf_rvalid), .pf_rlast(pf_rlast), .pf_rready(pf_rready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rresp(m_rresp),
      .m_rready(m_rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic miss(input logic [31:0] addr);
      miss_req = 1'b1;
      miss_addr = addr;
      step();
      miss_req = 1'b0;
   endtask

   // Entered with the DUT presenting the demand AR; ends one cycle after the refill pulse.
   task automatic cache_burst(input logic [31:0] line, input int ardly, input bit gaps, input bit seq);
      chk("ar_valid", m_arvalid, 1);
      chk("ar_addr", m_araddr, line);
      chk("ar_id", m_arid, 0);
      chk("ar_len", m_arlen, BL - 1);
      chk("ar_size", m_arsize, 2);
      chk("ar_burst", m_arburst, 1);
      repeat (ardly) begin
         step();
         chk("ar_hold_valid", m_arvalid, 1);
         chk("ar_hold_addr", m_araddr, line);
      end
      m_arready = 1'b1;
      #1 chk("ar_no_pf_arready", pf_arready, 0);
      step();
      m_arready = 1'b0;
      chk("r_ready", m_rready, 1);
      chk("r_arvalid_off", m_arvalid, 0);
      for (int i = 0; i < 8; i++) begin
         rdata[i] = seq ? 32'(i) : $urandom;
         if (gaps) repeat ($urandom_range(0, 2)) begin
            chk("r_no_refill", refill_valid, 0);
            step();
         end
         m_rvalid = 1'b1;
         m_rdata = rdata[i];
         m_rlast = (i == 7);
         step();
         m_rvalid = 1'b0;
         m_rlast = 1'b0;
      end
      #1;
      chk("done_valid", refill_valid, 1);
      chk("done_addr", refill_addr, line);
      for (int i = 0; i < 8; i++) chk("done_data", refill_data[i], rdata[i]);
      step();
      chk("done_pulse", refill_valid, 0);
   endtask

   task automatic demand(input logic [31:0] addr, input int ardly, input bit gaps, input bit seq);
      logic [31:0] line;
      bit hit;
      line = addr & 32'hFFFF_FFE0;
      hit = buff_ready && ((buff_addr & 32'hFFFF_FFE0) == line);
      miss(addr);
      chk("miss_quiet", {31'b0, refill_valid | m_arvalid}, 0);
      step();
      if (hit) begin
         chk("hit_valid", refill_valid, 1);
         chk("hit_addr", refill_addr, line);
         chk("hit_no_ar", m_arvalid, 0);
         for (int i = 0; i < 8; i++) chk("hit_data", refill_data[i], bdata[i]);
         step();
         chk("hit_pulse", refill_valid, 0);
         chk("hit_no_ar2", m_arvalid, 0);
      end else cache_burst(line, ardly, gaps, seq);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) bdata[i] = $urandom;
      #3;
      chk("rst_refill_valid", refill_valid, 0);
      chk("rst_refill_addr", refill_addr, 0);
      for (int i = 0; i < 8; i++) chk("rst_refill_data", refill_data[i], 0);
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_rready", m_rready, 0);
      chk("rst_pf_arready", pf_arready, 0);
      chk("rst_pf_rvalid", pf_rvalid, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      step();

      buff_ready = 1'b1;
      buff_addr = 32'h1FC0_0020;
      demand(32'h1FC0_0034, 0, 0, 0);

      buff_addr = 32'h1FC0_0040;
      demand(32'h0040_0018, 0, 0, 1);

      buff_ready = 1'b0;
      demand(32'h0070_1234, 5, 1, 0);

      p = 32'h0080_0040;
      pf_araddr = p;
      pf_arvalid = 1'b1;
      miss_req = 1'b1;
      miss_addr = 32'h0030_0008;
      step();
      miss_req = 1'b0;
      chk("pri_pf_arready", pf_arready, 0);
      chk("pri_idle_no_ar", m_arvalid, 0);
      step();
      cache_burst(32'h0030_0000, 1, 0, 0);
      chk("pf_wait_idle", m_arvalid, 0);
      step();
      chk("pf_arvalid", m_arvalid, 1);
      chk("pf_arid", m_arid, 1);
      chk("pf_araddr", m_araddr, p);
      chk("pf_arready_low", pf_arready, 0);
      m_arready = 1'b1;
      #1 chk("pf_arready_pass", pf_arready, 1);
      step();
      m_arready = 1'b0;
      pf_arvalid = 1'b0;
      m_rvalid = 1'b1;
      m_rlast = 1'b1;
      m_rdata = 32'hDEAD_BEEF;
      #1;
      chk("pf_stall_rready", m_rready, 0);
      chk("pf_stall_rvalid", pf_rvalid, 1);
      step();
      for (int i = 0; i < 8; i++) begin
         pf_rready = 1'b1;
         m_rvalid = 1'b1;
         m_rlast = (i == 7);
         m_rdata = $urandom;
         if (i == 3) begin
            miss_req = 1'b1;
            miss_addr = p + 32'd4;
         end
         #1;
         chk("pf_rdata", pf_rdata, m_rdata);
         chk("pf_rlast", pf_rlast, {31'b0, m_rlast});
         chk("pf_rready_pass", m_rready, 1);
         step();
         miss_req = 1'b0;
      end
      m_rvalid = 1'b0;
      m_rlast = 1'b0;
      pf_rready = 1'b0;
      buff_ready = 1'b1;
      buff_addr = p;
      for (int i = 0; i < 8; i++) bdata[i] = $urandom;
      m_rvalid = 1'b1;
      #1;
      chk("idle_pf_rvalid_zero", pf_rvalid, 0);
      chk("idle_rready_zero", m_rready, 0);
      m_rvalid = 1'b0;
      chk("pend_no_ar", m_arvalid, 0);
      step();
      chk("pend_hit_valid", refill_valid, 1);
      chk("pend_hit_addr", refill_addr, p);
      chk("pend_hit_no_ar", m_arvalid, 0);
      for (int i = 0; i < 8; i++) chk("pend_hit_data", refill_data[i], bdata[i]);
      step();
      chk("pend_hit_pulse", refill_valid, 0);
      chk("pend_no_second_ar", m_arvalid, 0);

      buff_ready = 1'b0;
      miss(32'h0050_0000);
      step();
      m_arready = 1'b1;
      step();
      m_arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_rvalid = 1'b1;
         m_rdata = 32'h1111_0000 + 32'(i);
         step();
      end
      m_rdata = 32'h2222_2222;
      rst = 1'b0;
      #1;
      chk("mid_rst_refill_valid", refill_valid, 0);
      chk("mid_rst_rready", m_rready, 0);
      chk("mid_rst_arvalid", m_arvalid, 0);
      chk("mid_rst_refill_addr", refill_addr, 0);
      for (int i = 0; i < 8; i++) chk("mid_rst_data", refill_data[i], 0);
      m_rvalid = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("post_rst_refill_valid", refill_valid, 0);
      chk("post_rst_no_pending", m_arvalid, 0);
      demand(32'h0060_0010, 0, 1, 0);

      for (int t = 0; t < 20; t++) begin
         a = $urandom;
         for (int i = 0; i < 8; i++) bdata[i] = $urandom;
         buff_ready = 1'($urandom_range(0, 1));
         buff_addr = ($urandom_range(0, 1) == 1) ? (a ^ 32'($urandom_range(0, 31))) : $urandom;
         demand(a, $urandom_range(0, 3), 1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifetch_refill_arbiter.md
IFETCH_REFILL_ARBITER -- requirements
Module: ifetch_refill_arbiter

Interface
REQ-001 Parameter BURST_LENGTH, default 8, beats per cache-line refill (32-byte line, 32-bit beats).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low; 0 resets all state immediately.
REQ-004 miss_req  in  1  single-cycle icache demand-miss pulse.
REQ-005 miss_addr  in  32  miss address, valid with miss_req.
REQ-006 refill_valid  out  1  single-cycle pulse; refill_addr and refill_data valid.
REQ-007 refill_addr  out  32  line address of the delivered line, low 5 bits zero.
REQ-008 refill_data[0:7]  out  8x32  line words, index = word offset.
REQ-009 buff_addr  in  32  prefetch buffer line address.
REQ-010 buff_data[0:7]  in  8x32  prefetch buffer words.
REQ-011 buff_ready  in  1  prefetch buffer holds a complete line.
REQ-012 pf_araddr, pf_arvalid  in  32, 1  prefetcher AR request.
REQ-013 pf_arready  out  1  AR accept to prefetcher.
REQ-014 pf_rdata, pf_rvalid, pf_rlast  out  32, 1, 1  R beats forwarded to prefetcher.
REQ-015 pf_rready  in  1  prefetcher R ready.
REQ-016 m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid  out  4, 32, 8, 3, 2, 1  AXI master AR.
REQ-017 m_arready  in  1  AXI AR ready.
REQ-018 m_rdata, m_rvalid, m_rlast, m_rresp  in  32, 1, 1, 2  AXI master R; m_rresp ignored.
REQ-019 m_rready  out  1  AXI R ready.

Function
REQ-020 States: IDLE, HIT, C_AR, C_R, DONE, P_AR, P_R.
REQ-021 A miss_req pulse sets a pending flag and latches line = {miss_addr[31:5],5'b0}; the flag clears on entry to HIT or C_AR.
REQ-022 IDLE with pending and buff_ready and buff_addr[31:5]==line[31:5] -> HIT; HIT copies buff_data and line to refill outputs and drives refill_valid=1 for exactly one cycle, then IDLE.
REQ-023 IDLE with pending and no buffer match -> C_AR; demand takes priority over a simultaneous pf_arvalid.
REQ-024 C_AR: m_arvalid=1, m_araddr=line, m_arid=0; m_arvalid&&m_arready -> C_R.
REQ-025 C_R: m_rready=1; each m_rvalid beat writes refill_data[count], count+1 (3-bit, saturating at 7); m_rvalid&&m_rlast -> DONE.
REQ-026 DONE: refill_valid=1 for one cycle, refill_addr=line, then IDLE; count cleared.
REQ-027 IDLE with no pending and pf_arvalid -> P_AR; P_AR passes pf_araddr to m_araddr, m_arid=1, m_arvalid=pf_arvalid, pf_arready=m_arready; handshake -> P_R.
REQ-028 P_R: pf_rdata=m_rdata, pf_rvalid=m_rvalid, pf_rlast=m_rlast, m_rready=pf_rready; m_rvalid&&pf_rready&&m_rlast -> IDLE.
REQ-029 A miss_req arriving in P_AR after handshake or in P_R is held pending; re-evaluated in IDLE after the prefetch completes (buffer may then hit).
REQ-030 miss_req in any non-IDLE cache state overwrites the latched line and stays pending; the in-flight refill completes unchanged.
REQ-031 m_arlen=BURST_LENGTH-1, m_arsize=2, m_arburst=2'b01 (INCR) constant.
REQ-032 All AR/R outputs zero outside their owning states; pf_* outputs zero when not in P_AR/P_R.

Reset
REQ-033 rst=0: state IDLE, pending=0, count=0, refill_valid=0, refill_addr=0, refill_data all 0, m_arvalid=0, m_rready=0, pf_arready=0, pf_rvalid=0.
REQ-034 Reset mid-burst abandons the transaction; no refill_valid emitted.

Verification
REQ-035 buff_ready=1, buff_addr=0x1FC00020, miss_req addr 0x1FC00034 -> refill_valid 2 cycles later, refill_addr=0x1FC00020, refill_data=buff_data, no m_arvalid.
REQ-036 Buffer mismatch, miss addr 0x00400018 -> m_araddr=0x00400000, arlen=7, arid=0; 8 beats 0..7 -> refill_data[i]=i, refill_valid one cycle after rlast.
REQ-037 miss_req and pf_arvalid same cycle -> demand AR issued first; prefetch AR granted after DONE.
REQ-038 miss_req during P_R on the prefetched line -> after rlast, HIT path taken, no second AXI burst.
REQ-039 m_arready held 0 for 5 cycles in C_AR -> m_arvalid and m_araddr stable throughout.
REQ-040 rst asserted at beat 4 of C_R -> outputs immediately at reset values, next miss refills correctly.
